// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, lookup tables and GF(2^8) helpers for the iterative core.
package aes128_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_BITS = 128;
  localparam int unsigned BYTE_BITS  = 8;

  typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} fsm_state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table derived from the forward table so the two can never disagree
  function automatic logic [0:255][7:0] build_inv_sbox();
    logic [0:255][7:0] t;
    t = '0;
    for (int unsigned i = 0; i < 256; i++) t[SBOX[8'(i)]] = 8'(i);
    return t;
  endfunction

  localparam logic [0:255][7:0] INV_SBOX = build_inv_sbox();

  localparam logic [1:10][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Byte idx of a block (idx = row + 4*col), byte 0 in the MSBs
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned idx);
    return s[(BLOCK_BITS - BYTE_BITS) - BYTE_BITS * idx +: BYTE_BITS];
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round, forward or inverse, with optional MixColumns skip for the final round.
module aes_round
  import aes128_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         decrypt,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [0:3][7:0] coef;
    logic [7:0]      acc;
    logic [127:0]    res;
    coef = inv ? 32'h0e0b0d09 : 32'h02030101;
    res  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        acc = '0;
        for (int unsigned k = 0; k < 4; k++)
          acc = acc ^ gmul(get_byte(s, k + 4 * c), coef[2'((k + 4 - r) % 4)]);
        res[120 - 8 * (r + 4 * c) +: 8] = acc;
      end
    end
    return res;
  endfunction

  // Byte substitution fused with the row rotation; the two operations commute
  always_comb begin
    subbed = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (decrypt)
          subbed[120 - 8 * (r + 4 * c) +: 8] = INV_SBOX[get_byte(state_in, r + 4 * ((c + 4 - r) % 4))];
        else
          subbed[120 - 8 * (r + 4 * c) +: 8] = SBOX[get_byte(state_in, r + 4 * ((c + r) % 4))];
      end
    end
  end

  assign keyed     = subbed ^ round_key;
  assign mixed     = mix(subbed, 1'b0);
  assign state_out = decrypt ? (last ? keyed : mix(keyed, 1'b1))
                             : ((last ? subbed : mixed) ^ round_key);

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encrypt/decrypt engine with stored key schedule and valid/ready handshakes.
module aes128_iter_core
  import aes128_pkg::*;
#(
  parameter int unsigned UNROLL   = 1,
  parameter int unsigned KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned STEPS = NUM_ROUNDS / UNROLL;

  if (KEY_BITS != 128) begin : g_bad_key
    $error("aes128_iter_core: only KEY_BITS=128 is supported");
  end
  if (UNROLL == 0 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must divide 10");
  end

  fsm_state_t   state;
  logic [127:0] rk [NUM_ROUNDS + 1];
  logic [127:0] kw;
  logic [127:0] knext;
  logic [31:0]  rot;
  logic [31:0]  ktemp;
  logic [3:0]   kcnt;
  logic [3:0]   rcnt;
  logic [127:0] blk;
  logic         dec_q;
  logic [127:0] chain [UNROLL + 1];

  assign in_ready = (state == IDLE) && key_ready && !key_load;

  // Next round key from the previous one
  always_comb begin
    rot            = {kw[23:0], kw[31:24]};
    ktemp          = {SBOX[rot[31:24]] ^ RCON[kcnt + 4'd1], SBOX[rot[23:16]],
                      SBOX[rot[15:8]], SBOX[rot[7:0]]};
    knext[127:96]  = kw[127:96] ^ ktemp;
    knext[95:64]   = kw[95:64]  ^ knext[127:96];
    knext[63:32]   = kw[63:32]  ^ knext[95:64];
    knext[31:0]    = kw[31:0]   ^ knext[63:32];
  end

  assign chain[0] = blk;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [3:0]   rnum;
    logic [127:0] rkey;
    logic         last;
    assign rnum = 4'(rcnt * UNROLL + j + 1);
    assign rkey = dec_q ? rk[4'(NUM_ROUNDS) - rnum] : rk[rnum];
    assign last = (rnum == 4'(NUM_ROUNDS));
    aes_round u_round (
      .state_in  (chain[j]),
      .round_key (rkey),
      .decrypt   (dec_q),
      .last      (last),
      .state_out (chain[j+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rk        <= '{default: '0};
      kw        <= '0;
      kcnt      <= '0;
      rcnt      <= '0;
      blk       <= '0;
      dec_q     <= 1'b0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            state     <= KEYEXP;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            kcnt      <= '0;
            rk[0]     <= key_in;
            kw        <= key_in;
          end else if (in_valid && in_ready) begin
            state <= RUN;
            busy  <= 1'b1;
            rcnt  <= '0;
            dec_q <= in_decrypt;
            blk   <= in_data ^ (in_decrypt ? rk[NUM_ROUNDS] : rk[0]);
          end
        end
        KEYEXP: begin
          rk[kcnt + 4'd1] <= knext;
          kw              <= knext;
          kcnt            <= kcnt + 4'd1;
          if (kcnt == 4'(NUM_ROUNDS - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            kcnt      <= '0;
          end
        end
        RUN: begin
          blk  <= chain[UNROLL];
          rcnt <= rcnt + 4'd1;
          if (rcnt == 4'(STEPS - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            rcnt     <= '0;
            out_data <= chain[UNROLL];
          end
        end
        DONE: begin
          // out_valid rises one edge after the result is latched
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed FIPS-197 vector bench for aes128_iter_core at UNROLL 1, 2 and 10.
module tb_aes128_iter_core;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in, in_data;
  logic         in_decrypt;
  logic         kl_1, iv_1, or_1, kl_2, iv_2, or_2, kl_10, iv_10, or_10;
  logic         kr_1, ir_1, ov_1, bz_1, kr_2, ir_2, ov_2, bz_2, kr_10, ir_10, ov_10, bz_10;
  logic [127:0] od_1, od_2, od_10;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes128_iter_core #(.UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(kl_1), .key_in(key_in), .key_ready(kr_1),
    .in_valid(iv_1), .in_ready(ir_1), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(ov_1), .out_ready(or_1), .out_data(od_1), .busy(bz_1));

  aes128_iter_core #(.UNROLL(2)) dut_u2 (
    .clk(clk), .rst_n(rst_n), .key_load(kl_2), .key_in(key_in), .key_ready(kr_2),
    .in_valid(iv_2), .in_ready(ir_2), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(ov_2), .out_ready(or_2), .out_data(od_2), .busy(bz_2));

  aes128_iter_core #(.UNROLL(10)) dut_u10 (
    .clk(clk), .rst_n(rst_n), .key_load(kl_10), .key_in(key_in), .key_ready(kr_10),
    .in_valid(iv_10), .in_ready(ir_10), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(ov_10), .out_ready(or_10), .out_data(od_10), .busy(bz_10));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_kl(input int sel, input logic v);
    case (sel) 0: kl_1 = v; 1: kl_2 = v; default: kl_10 = v; endcase
  endtask
  task automatic set_iv(input int sel, input logic v);
    case (sel) 0: iv_1 = v; 1: iv_2 = v; default: iv_10 = v; endcase
  endtask
  task automatic set_or(input int sel, input logic v);
    case (sel) 0: or_1 = v; 1: or_2 = v; default: or_10 = v; endcase
  endtask
  function automatic logic get_kr(input int sel);
    return (sel == 0) ? kr_1 : (sel == 1) ? kr_2 : kr_10;
  endfunction
  function automatic logic get_ov(input int sel);
    return (sel == 0) ? ov_1 : (sel == 1) ? ov_2 : ov_10;
  endfunction
  function automatic logic [127:0] get_od(input int sel);
    return (sel == 0) ? od_1 : (sel == 1) ? od_2 : od_10;
  endfunction

  // Pulse key_load and return edges until key_ready (40 means timed out)
  task automatic load_key(input int sel, input logic [127:0] k, output int cyc);
    key_in = k;
    set_kl(sel, 1'b1);
    step();
    set_kl(sel, 1'b0);
    cyc = 0;
    while (!get_kr(sel) && cyc < 40) begin step(); cyc++; end
  endtask

  // Offer one block with out_ready=1, return result and accept-to-out_valid edges
  task automatic run_block(input int sel, input logic dec, input logic [127:0] d,
                           output logic [127:0] res, output int lat);
    in_data = d;
    in_decrypt = dec;
    set_iv(sel, 1'b1);
    set_or(sel, 1'b1);
    step();
    set_iv(sel, 1'b0);
    lat = 0;
    while (!get_ov(sel) && lat < 40) begin step(); lat++; end
    res = get_od(sel);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_vec++; if (kr_1 !== 1'b0) begin n_err++; $display("FAIL reset_key_ready got %b want 0", kr_1); end
    n_vec++; if (ir_1 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", ir_1); end
    n_vec++; if (ov_1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ov_1); end
    n_vec++; if (od_1 !== 128'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", od_1); end
    n_vec++; if (bz_1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bz_1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips_encrypt();
    int cyc, lat;
    key_in = KEY_A;
    kl_1 = 1'b1;
    step();
    kl_1 = 1'b0;
    n_vec++; if (bz_1 !== 1'b1) begin n_err++; $display("FAIL keyexp_busy got %b want 1", bz_1); end
    cyc = 1;
    while (!kr_1 && cyc < 40) begin step(); cyc++; end
    n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL keyexp_cycles got %0d want 11", cyc); end
    n_vec++; if (ir_1 !== 1'b1) begin n_err++; $display("FAIL enc_in_ready got %b want 1", ir_1); end
    in_data = PT_A; in_decrypt = 1'b0; iv_1 = 1'b1; or_1 = 1'b1;
    step();
    iv_1 = 1'b0;
    n_vec++; if (bz_1 !== 1'b1 || ir_1 !== 1'b0) begin
      n_err++; $display("FAIL run_busy_ready got busy=%b ready=%b want 1/0", bz_1, ir_1); end
    lat = 0;
    while (!ov_1 && lat < 40) begin step(); lat++; end
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL enc_latency got %0d want 11", lat); end
    n_vec++; if (od_1 !== CT_A) begin n_err++; $display("FAIL enc_fips_b got %h want %h", od_1, CT_A); end
    step();
    n_vec++; if (ov_1 !== 1'b0) begin n_err++; $display("FAIL enc_handshake got out_valid=%b want 0", ov_1); end
  endtask

  task automatic test_fips_decrypt();
    int exp_lat [3] = '{11, 6, 2};
    int cyc, lat;
    logic [127:0] res;
    for (int sel = 0; sel < 3; sel++) begin
      load_key(sel, KEY_C, cyc);
      n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL dec_keyexp[%0d] got %0d want 10", sel, cyc); end
      run_block(sel, 1'b1, CT_C, res, lat);
      n_vec++; if (res !== PT_C) begin n_err++; $display("FAIL dec_c1[%0d] got %h want %h", sel, res, PT_C); end
      n_vec++; if (lat !== exp_lat[sel]) begin
        n_err++; $display("FAIL dec_latency[%0d] got %0d want %0d", sel, lat, exp_lat[sel]); end
      run_block(sel, 1'b0, PT_C, res, lat);
      n_vec++; if (res !== CT_C) begin n_err++; $display("FAIL enc_c1[%0d] got %h want %h", sel, res, CT_C); end
    end
  endtask

  task automatic test_back_pressure();
    int cyc, lat;
    logic [127:0] held;
    load_key(0, KEY_A, cyc);
    or_1 = 1'b0; in_data = PT_A; in_decrypt = 1'b0; iv_1 = 1'b1;
    step();
    iv_1 = 1'b0;
    lat = 0;
    while (!ov_1 && lat < 40) begin step(); lat++; end
    held = od_1;
    n_vec++; if (held !== CT_A) begin n_err++; $display("FAIL bp_result got %h want %h", held, CT_A); end
    iv_1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_vec++; if (od_1 !== CT_A || ov_1 !== 1'b1 || ir_1 !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got data=%h valid=%b ready=%b want %h/1/0", i, od_1, ov_1, ir_1, CT_A); end
    end
    or_1 = 1'b1;
    step();
    n_vec++; if (ov_1 !== 1'b0 || ir_1 !== 1'b1 || od_1 !== CT_A) begin
      n_err++; $display("FAIL bp_release got valid=%b ready=%b data=%h want 0/1/%h", ov_1, ir_1, od_1, CT_A); end
    step();
    iv_1 = 1'b0;
    n_vec++; if (bz_1 !== 1'b1) begin n_err++; $display("FAIL bp_next_accept got busy=%b want 1", bz_1); end
    lat = 0;
    while (!ov_1 && lat < 40) begin step(); lat++; end
    n_vec++; if (od_1 !== CT_A) begin n_err++; $display("FAIL bp_next_result got %h want %h", od_1, CT_A); end
    step();
  endtask

  task automatic test_key_load_ignored();
    int cyc, lat;
    key_in = KEY_A; kl_1 = 1'b1;
    step();
    kl_1 = 1'b0;
    repeat (4) step();
    key_in = 128'h0; kl_1 = 1'b1;
    step();
    kl_1 = 1'b0; key_in = KEY_A;
    cyc = 5;
    while (!kr_1 && cyc < 40) begin step(); cyc++; end
    n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL kl_in_keyexp got %0d edges want 10", cyc); end
    in_data = PT_A; in_decrypt = 1'b0; iv_1 = 1'b1; or_1 = 1'b1;
    step();
    iv_1 = 1'b0;
    repeat (2) step();
    key_in = 128'h0; kl_1 = 1'b1;
    step();
    kl_1 = 1'b0; key_in = KEY_A;
    n_vec++; if (bz_1 !== 1'b1 || kr_1 !== 1'b1) begin
      n_err++; $display("FAIL kl_in_run got busy=%b key_ready=%b want 1/1", bz_1, kr_1); end
    lat = 3;
    while (!ov_1 && lat < 40) begin step(); lat++; end
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL kl_run_latency got %0d want 11", lat); end
    n_vec++; if (od_1 !== CT_A) begin n_err++; $display("FAIL kl_run_result got %h want %h", od_1, CT_A); end
    step();
    key_in = KEY_A; kl_1 = 1'b1; iv_1 = 1'b1; in_data = PT_A;
    #1;
    n_vec++; if (ir_1 !== 1'b0) begin n_err++; $display("FAIL kl_vs_valid_ready got %b want 0", ir_1); end
    step();
    kl_1 = 1'b0; iv_1 = 1'b0;
    n_vec++; if (bz_1 !== 1'b1 || kr_1 !== 1'b0) begin
      n_err++; $display("FAIL kl_vs_valid_keyexp got busy=%b key_ready=%b want 1/0", bz_1, kr_1); end
    cyc = 0;
    while (!kr_1 && cyc < 40) begin step(); cyc++; end
    n_vec++; if (ov_1 !== 1'b0 || kr_1 !== 1'b1) begin
      n_err++; $display("FAIL kl_vs_valid_after got valid=%b key_ready=%b want 0/1", ov_1, kr_1); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, lat;
    logic [127:0] res;
    in_data = PT_A; in_decrypt = 1'b0; iv_1 = 1'b1; or_1 = 1'b1;
    step();
    iv_1 = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_vec++; if (kr_1 !== 1'b0 || ir_1 !== 1'b0 || bz_1 !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl got key_ready=%b in_ready=%b busy=%b want 0/0/0", kr_1, ir_1, bz_1); end
    n_vec++; if (ov_1 !== 1'b0 || od_1 !== 128'h0) begin
      n_err++; $display("FAIL midrst_out got valid=%b data=%h want 0/0", ov_1, od_1); end
    step();
    rst_n = 1'b1;
    step();
    load_key(0, KEY_A, cyc);
    run_block(0, 1'b0, PT_A, res, lat);
    n_vec++; if (res !== CT_A) begin n_err++; $display("FAIL midrst_reload got %h want %h", res, CT_A); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        run_block(0, 1'b0, PT_A, res, lat);
        n_vec++; if (res !== CT_A) begin n_err++; $display("FAIL b2b_enc[%0d] got %h want %h", i, res, CT_A); end
      end else begin
        run_block(0, 1'b1, CT_A, res, lat);
        n_vec++; if (res !== PT_A) begin n_err++; $display("FAIL b2b_dec[%0d] got %h want %h", i, res, PT_A); end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_in = '0; in_data = '0; in_decrypt = 1'b0;
    kl_1 = 1'b0; iv_1 = 1'b0; or_1 = 1'b0;
    kl_2 = 1'b0; iv_2 = 1'b0; or_2 = 1'b0;
    kl_10 = 1'b0; iv_10 = 1'b0; or_10 = 1'b0;
    #1;
    test_reset();
    test_fips_encrypt();
    test_fips_decrypt();
    test_back_pressure();
    test_key_load_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
